// File: rtl/bidir_buffer_if.sv
// Control/status bundle for bidir_buffer: direction request in, registered status out.
// The tri-state buses a/b stay as plain inout ports on the buffer itself.
interface bidir_buffer_if;
  logic en;
  logic a2b_active;
  logic b2a_active;
  logic turnaround;

  modport master (output en, input a2b_active, b2a_active, turnaround);
  modport slave  (input en, output a2b_active, b2a_active, turnaround);
endinterface

// File: rtl/bidir_buffer.sv
// Bidirectional tri-state bridge between buses a and b; direction from ctl.en, Hi-Z turnaround between directions.
// Latency: data 0 clocks (combinational); direction request to new drive 1 + TURN_CYCLES clocks.
// Backpressure: none; BIDIR_CAPTURE_EN adds data_q, a register of the passed-through value.
module bidir_buffer #(
  parameter int WIDTH       = 1,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  bidir_buffer_if.slave    ctl,
`ifdef BIDIR_CAPTURE_EN
  output logic [WIDTH-1:0] data_q,
`endif
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b
);

  typedef enum logic [1:0] {HIZ, A2B, B2A, TURN} state_t;

  localparam logic [3:0] TURN_LOAD = 4'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       tgt_q, tgt_d;   // 1 = heading for A2B

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HIZ;
      cnt_q   <= 4'd0;
      tgt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    case (state_q)
      HIZ: state_d = ctl.en ? A2B : B2A;
      A2B: begin
        if (!ctl.en) begin
          if (TURN_CYCLES == 0) begin
            state_d = B2A;
          end else begin
            state_d = TURN;
            tgt_d   = 1'b0;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      B2A: begin
        if (ctl.en) begin
          if (TURN_CYCLES == 0) begin
            state_d = A2B;
          end else begin
            state_d = TURN;
            tgt_d   = 1'b1;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      TURN: begin
        // The target follows en while counting, but the count never restarts.
        if (cnt_q == 4'd0) begin
          state_d = tgt_q ? A2B : B2A;
        end else begin
          cnt_d = cnt_q - 4'd1;
          tgt_d = ctl.en;
        end
      end
      default: state_d = HIZ;
    endcase
  end

  assign b = (state_q == A2B) ? a : {WIDTH{1'bz}};
  assign a = (state_q == B2A) ? b : {WIDTH{1'bz}};

  assign ctl.a2b_active = (state_q == A2B);
  assign ctl.b2a_active = (state_q == B2A);
  assign ctl.turnaround = (state_q == HIZ) || (state_q == TURN);

`ifdef BIDIR_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (state_q == A2B) begin
      data_q <= a;
    end else if (state_q == B2A) begin
      data_q <= b;
    end
  end
`endif

endmodule

// File: tb/tb_bidir_buffer.sv
// Bench for bidir_buffer: three instances (W1/T1, W8/T0, W8/T3) sharing clk, rst_n and en,
// checked against a directed table and a cycle-level reference model under random stimulus.
module tb_bidir_buffer;

  localparam int       NI       = 3;
  localparam int       TC[NI]   = '{1, 0, 3};
  localparam bit [7:0] MASK[NI] = '{8'h01, 8'hFF, 8'hFF};

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  always #5 clk = ~clk;

  logic [7:0] a_drv[NI], b_drv[NI];
  logic       a_oe[NI], b_oe[NI];

  wire       a0, b0;
  wire [7:0] a1, b1, a2, b2;

  assign a0 = a_oe[0] ? a_drv[0][0] : 1'bz;
  assign b0 = b_oe[0] ? b_drv[0][0] : 1'bz;
  assign a1 = a_oe[1] ? a_drv[1] : 8'hzz;
  assign b1 = b_oe[1] ? b_drv[1] : 8'hzz;
  assign a2 = a_oe[2] ? a_drv[2] : 8'hzz;
  assign b2 = b_oe[2] ? b_drv[2] : 8'hzz;

  bidir_buffer_if if0 ();
  bidir_buffer_if if1 ();
  bidir_buffer_if if2 ();
  assign if0.en = en;
  assign if1.en = en;
  assign if2.en = en;

`ifdef BIDIR_CAPTURE_EN
  logic       dq0;
  logic [7:0] dq1, dq2;
`endif

  bidir_buffer #(.WIDTH(1), .TURN_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .ctl(if0),
`ifdef BIDIR_CAPTURE_EN
    .data_q(dq0),
`endif
    .a(a0), .b(b0));
  bidir_buffer #(.WIDTH(8), .TURN_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .ctl(if1),
`ifdef BIDIR_CAPTURE_EN
    .data_q(dq1),
`endif
    .a(a1), .b(b1));
  bidir_buffer #(.WIDTH(8), .TURN_CYCLES(3)) u2 (
    .clk(clk), .rst_n(rst_n), .ctl(if2),
`ifdef BIDIR_CAPTURE_EN
    .data_q(dq2),
`endif
    .a(a2), .b(b2));

  wire [7:0] a_rd[NI];
  wire [7:0] b_rd[NI];
  wire [2:0] st[NI];
  assign a_rd[0] = {7'd0, a0};
  assign b_rd[0] = {7'd0, b0};
  assign a_rd[1] = a1;
  assign b_rd[1] = b1;
  assign a_rd[2] = a2;
  assign b_rd[2] = b2;
  assign st[0] = {if0.a2b_active, if0.b2a_active, if0.turnaround};
  assign st[1] = {if1.a2b_active, if1.b2a_active, if1.turnaround};
  assign st[2] = {if2.a2b_active, if2.b2a_active, if2.turnaround};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: direction currently owned, plus remaining Hi-Z clocks of a pending turn.
  // Codes: 0 = nobody driven, 1 = a drives b, 2 = b drives a.
  bit         started[NI];
  bit         dir[NI];
  bit         tgt[NI];
  int         tl[NI];
  logic [7:0] dq_m[NI];
  logic [1:0] cur_code[NI];
  bit         ph = 1'b0;

  function automatic logic [1:0] model_code(int i);
    if (!started[i] || tl[i] > 0) return 2'd0;
    return dir[i] ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [2:0] onehot(logic [1:0] c);
    return (c == 2'd1) ? 3'b100 : (c == 2'd2) ? 3'b010 : 3'b001;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      started[i] = 1'b0;
      dir[i]     = 1'b0;
      tgt[i]     = 1'b0;
      tl[i]      = 0;
      dq_m[i]    = 8'h00;
    end
  endtask

  task automatic model_clock(bit e);
    for (int i = 0; i < NI; i++) begin
      if (cur_code[i] == 2'd1) dq_m[i] = a_drv[i] & MASK[i];
      if (cur_code[i] == 2'd2) dq_m[i] = b_drv[i] & MASK[i];
      if (!started[i]) begin
        started[i] = 1'b1;
        dir[i]     = e;
      end else if (tl[i] > 0) begin
        tl[i]--;
        if (tl[i] == 0) dir[i] = tgt[i];
        else            tgt[i] = e;
      end else if (e != dir[i]) begin
        if (TC[i] == 0) begin
          dir[i] = e;
        end else begin
          tl[i]  = TC[i];
          tgt[i] = e;
        end
      end
    end
  endtask

  task automatic chk(string nm, int i, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h, expected %h", nm, i, act, exp);
    end
  endtask

  // One clock: apply rst_n/en just after a rising edge, drive the buses per the expected
  // direction, check on the falling edge, then advance the model on the next rising edge.
  task automatic step(bit r, bit e, bit use_tbl, logic [2:0][1:0] tcode);
    rst_n = r;
    en    = e;
    if (!r) model_reset();
    ph = ~ph;
    for (int i = 0; i < NI; i++) begin
      cur_code[i] = use_tbl ? tcode[i] : model_code(i);
      case (cur_code[i])
        2'd1: begin
          a_oe[i] = 1'b1; b_oe[i] = 1'b0;
          a_drv[i] = 8'($urandom);
        end
        2'd2: begin
          a_oe[i] = 1'b0; b_oe[i] = 1'b1;
          b_drv[i] = 8'($urandom);
        end
        default: begin
          // Complementary patterns, swapped every clock, expose a stray driver on either side.
          a_oe[i] = 1'b1; b_oe[i] = 1'b1;
          a_drv[i] = ph ? 8'hFF : 8'h00;
          b_drv[i] = ph ? 8'h00 : 8'hFF;
        end
      endcase
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("status", i, {5'd0, st[i]}, {5'd0, onehot(cur_code[i])});
      case (cur_code[i])
        2'd1: chk("b_follows_a", i, b_rd[i], a_drv[i] & MASK[i]);
        2'd2: chk("a_follows_b", i, a_rd[i], b_drv[i] & MASK[i]);
        default: begin
          chk("hiz_a", i, a_rd[i], a_drv[i] & MASK[i]);
          chk("hiz_b", i, b_rd[i], b_drv[i] & MASK[i]);
        end
      endcase
    end
`ifdef BIDIR_CAPTURE_EN
    chk("data_q", 0, {7'd0, dq0}, dq_m[0]);
    chk("data_q", 1, dq1, dq_m[1]);
    chk("data_q", 2, dq2, dq_m[2]);
`endif
    @(posedge clk);
    if (r) model_clock(e);
    #1;
  endtask

  typedef struct {
    bit               rst_n;
    bit               en;
    logic [2:0][1:0]  exp;   // exp[i]: expected code for instance i
  } vec_t;

  vec_t tbl[17];

  initial begin
    // exp packed as {u2, u1, u0}; 0 = Hi-Z, 1 = A2B, 2 = B2A
    tbl[0]  = '{1'b0, 1'b1, {2'd0, 2'd0, 2'd0}};
    tbl[1]  = '{1'b0, 1'b1, {2'd0, 2'd0, 2'd0}};
    tbl[2]  = '{1'b1, 1'b1, {2'd0, 2'd0, 2'd0}};
    tbl[3]  = '{1'b1, 1'b1, {2'd1, 2'd1, 2'd1}};
    tbl[4]  = '{1'b1, 1'b1, {2'd1, 2'd1, 2'd1}};
    tbl[5]  = '{1'b1, 1'b0, {2'd1, 2'd1, 2'd1}};
    tbl[6]  = '{1'b1, 1'b1, {2'd0, 2'd2, 2'd0}};
    tbl[7]  = '{1'b1, 1'b1, {2'd0, 2'd1, 2'd2}};
    tbl[8]  = '{1'b1, 1'b1, {2'd0, 2'd1, 2'd0}};
    tbl[9]  = '{1'b1, 1'b0, {2'd1, 2'd1, 2'd1}};
    tbl[10] = '{1'b1, 1'b0, {2'd0, 2'd2, 2'd0}};
    tbl[11] = '{1'b1, 1'b0, {2'd0, 2'd2, 2'd2}};
    tbl[12] = '{1'b1, 1'b0, {2'd0, 2'd2, 2'd2}};
    tbl[13] = '{1'b1, 1'b0, {2'd2, 2'd2, 2'd2}};
    tbl[14] = '{1'b0, 1'b0, {2'd0, 2'd0, 2'd0}};
    tbl[15] = '{1'b1, 1'b0, {2'd0, 2'd0, 2'd0}};
    tbl[16] = '{1'b1, 1'b0, {2'd2, 2'd2, 2'd2}};

    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < NI; i++) begin
      a_oe[i] = 1'b0; b_oe[i] = 1'b0;
      a_drv[i] = 8'h00; b_drv[i] = 8'h00;
      cur_code[i] = 2'd0;
    end
    model_reset();
    @(posedge clk);
    #1;

    for (int k = 0; k < 17; k++) begin
      step(tbl[k].rst_n, tbl[k].en, 1'b1, tbl[k].exp);
    end

    // Hand sequence: abort a T=3 turn right after it starts, then a reset landing mid-turn.
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    for (int k = 0; k < 400; k++) begin
      bit e_n;
      bit r_n;
      e_n = ($urandom_range(0, 3) == 0) ? ~en : en;
      r_n = ($urandom_range(0, 59) != 0);
      step(r_n, e_n, 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bidir_buffer.md
Name: bidir_buffer

Overview:
- Clocked bidirectional buffer between two tri-state buses, a and b.
- en selects the transfer direction: en=1 means a drives b; en=0 means b drives a.
- Data passes through combinationally. Direction changes are registered, and a programmable all-Hi-Z turnaround window between directions prevents bus contention.
- Sits at a shared-bus boundary, e.g. a pad/port bridge between two bidirectional nets.

Parameters:
- WIDTH, 1, bit width of buses a and b.
- TURN_CYCLES, 1, number of clocks both sides stay Hi-Z on a direction change; 0 means switch directly. Legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  requested direction: 1 = a→b, 0 = b→a; sampled on clk.
- a  inout  WIDTH  side-A bus; driven only in state B2A.
- b  inout  WIDTH  side-B bus; driven only in state A2B.
- a2b_active  output  1  high in state A2B.
- b2a_active  output  1  high in state B2A.
- turnaround  output  1  high in states HIZ and TURN, i.e. neither side driven.

Behaviour:
- FSM states: HIZ, A2B, B2A, TURN; a turn counter of 4 bits; a registered target direction.
- Reset (rst_n=0, asynchronous, at any time, including mid-turnaround):
  - state=HIZ, counter=0.
  - a and b both 'z'.
  - a2b_active=0, b2a_active=0, turnaround=1.
- HIZ: on the first clock with rst_n=1, go to A2B if en=1, else B2A. There is no turnaround from HIZ.
- A2B:
  - b = a combinationally (zero latency, bitwise); a is never driven.
  - If sampled en=0: go to TURN with target B2A and counter=TURN_CYCLES-1.
  - If TURN_CYCLES=0, go straight to B2A.
- B2A: mirror of A2B. a = b combinationally; b never driven; sampled en=1 starts the turn toward A2B.
- TURN:
  - a and b both 'z'.
  - Counter decrements each clock; when it reaches 0, the next clock enters the target state.
  - TURN therefore lasts exactly TURN_CYCLES clocks.
- en changes during TURN:
  - The target is re-evaluated every clock.
  - If en returns to the original direction, the new target becomes that direction, but the count is not restarted.
  - The window always completes before any side is driven.
- en toggling between clock edges has no effect; only the value at the rising edge matters.
- Data values, including x and z, pass through unmodified. The buffer never drives both sides in the same cycle.
- Status outputs are decoded from registered state only: glitch-free, and exactly one of a2b_active, b2a_active, turnaround is high at any time.
- Latency:
  - Direction request to new drive: 1 + TURN_CYCLES clocks.
  - Data: 0 clocks, combinational.

Optional Feature:
- Macro: BIDIR_CAPTURE_EN.
- When defined:
  - Adds output port data_q (WIDTH).
  - Each rising clock in A2B, data_q <= a; in B2A, data_q <= b.
  - data_q holds its value in HIZ and TURN.
  - Reset value 0 (asynchronous).
- When undefined: port data_q and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, en=1, testbench drives nothing → a=z, b=z, turnaround=1, a2b_active=0, b2a_active=0.
- Forward pass (WIDTH=1, TURN_CYCLES=1): release reset with en=1, then after 1 clock step a through 0,1 → b follows 0,1 in the same timestep; a2b_active=1.
- Direction change: in A2B, set en=0 → for exactly 1 clock a=z, b=z, turnaround=1; next clock b2a_active=1; testbench drives b=1 → a=1.
- Zero turnaround (TURN_CYCLES=0, WIDTH=8): en toggles 1→0 → next clock goes directly to B2A; b=8'hA5 gives a=8'hA5, with no Hi-Z cycle.
- Abort during TURN (TURN_CYCLES=3): A2B, en=0 for 1 clock, then en=1 → 3 clocks Hi-Z, then back to A2B; there is never a cycle with both a and b driven by the DUT.
- Async reset mid-transfer: in B2A with a=1, pull rst_n low between edges → a and b go z immediately. With BIDIR_CAPTURE_EN defined, data_q=0.
